// File: rtl/qubitbytes_alive_if.sv
// TinyTapeout user-pin bundle for the ALIVE letter display.
interface qubitbytes_alive_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/qubitbytes_alive.sv
// Spells "ALIVE" plus one blank slot on the 7-segment output, one letter per
// prescaler period, with a heartbeat on uo_out[7] and the letter index on uio.
module qubitbytes_alive #(
    parameter int BASE_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    qubitbytes_alive_if.slave bus
);
    localparam int CW = BASE_LOG2 + 15;

    logic          pause;
    logic          blank;
    logic          reverse;
    logic [3:0]    speed;
    logic [CW-1:0] count_q;
    logic [CW-1:0] limit;
    logic          step;
    logic [2:0]    index_q;
    logic [2:0]    index_next;
    logic          heartbeat_q;
    logic [6:0]    seg;
    logic          unused_pins;

    assign pause   = bus.ui_in[0];
    assign blank   = bus.ui_in[1];
    assign reverse = bus.ui_in[2];
    assign speed   = bus.ui_in[7:4];

    // ena, uio_in and ui_in[3] carry no function in this block
    assign unused_pins = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[3]};

    // At s = 15 the shift reaches the counter width, wraps to zero, and the
    // subtraction yields all-ones, which is exactly 2^CW - 1.
    assign limit = (CW'(1) << (BASE_LOG2 + int'(speed))) - CW'(1);

    // ">=" rather than "==" so a mid-count speed decrease steps at once.
    assign step = !pause && (count_q >= limit);

    // Forward wraps 5 -> 0, reverse wraps 0 -> 5; the blank slot is index 5.
    always_comb begin
        index_next = index_q;
        if (reverse) begin
            index_next = (index_q == 3'd0) ? 3'd5 : index_q - 3'd1;
        end else begin
            index_next = (index_q == 3'd5) ? 3'd0 : index_q + 3'd1;
        end
    end

    // Prescaler: holds while paused, clears on a step, otherwise counts up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!pause) begin
            if (step) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    // Letter index and heartbeat advance together on every step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q     <= 3'd0;
            heartbeat_q <= 1'b0;
        end else if (step) begin
            index_q     <= index_next;
            heartbeat_q <= ~heartbeat_q;
        end
    end

    // Glyph decode, segments gfedcba active high; 6 and 7 never occur.
    always_comb begin
        seg = 7'h00;
        case (index_q)
            3'd0:    seg = 7'h77;
            3'd1:    seg = 7'h38;
            3'd2:    seg = 7'h06;
            3'd3:    seg = 7'h3E;
            3'd4:    seg = 7'h79;
            default: seg = 7'h00;
        endcase
    end

    assign bus.uo_out  = {heartbeat_q, blank ? 7'h00 : seg};
    assign bus.uio_out = {5'b00000, index_q};
    assign bus.uio_oe  = 8'b0000_0111;
endmodule

// File: tb/tb_qubitbytes_alive.sv
// Randomized scoreboard bench for qubitbytes_alive with directed corner cases.
module tb_qubitbytes_alive;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    qubitbytes_alive_if bus ();

    qubitbytes_alive #(.BASE_LOG2(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input byte c);
        case (c)
            "A":     return 7'h77;
            "L":     return 7'h38;
            "I":     return 7'h06;
            "V":     return 7'h3E;
            "E":     return 7'h79;
            default: return 7'h00;
        endcase
    endfunction

    // Reference model: a position into the displayed word and the number of
    // unpaused clocks spent on the current letter.
    string word = "ALIVE ";
    int    m_elapsed = 0;
    int    m_pos = 0;
    logic  m_hb = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_elapsed = 0;
            m_pos     = 0;
            m_hb      = 1'b0;
        end else if (!bus.ui_in[0]) begin
            int period;
            period = 1 << (8 + int'(bus.ui_in[7:4]));
            if (m_elapsed + 1 >= period) begin
                exp_t e;
                m_elapsed = 0;
                m_pos = bus.ui_in[2] ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
                m_hb  = ~m_hb;
                e.uo  = {m_hb, bus.ui_in[1] ? 7'h00 : glyph(word[m_pos])};
                e.uio = 8'(m_pos);
                sb.push_back(e);
            end else begin
                m_elapsed++;
            end
        end
    end

    // Monitor: a heartbeat edge marks a step, which must match the next expectation.
    logic prev_hb = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_hb = 1'b0;
                sb.delete();
            end else begin
                if (bus.uo_out[7] !== prev_hb) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_step: got uo_out %02h expected no step at %0t",
                                 bus.uo_out, $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("step_uo_out", bus.uo_out, e.uo);
                        check("step_uio_out", bus.uio_out, e.uio);
                    end
                end else if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_step: got uo_out %02h expected %02h at %0t",
                             bus.uo_out, e.uo, $time);
                end
                prev_hb = bus.uo_out[7];
            end
        end
    end

    task automatic do_reset(input logic [7:0] ui);
        @(negedge clk);
        rst_n = 1'b0;
        bus.ui_in = ui;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic at_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] fwd_uo [6] = '{8'hB8, 8'h06, 8'hBE, 8'h79, 8'h80, 8'h77};

    initial begin
        bus.ena    = 1'b1;
        bus.uio_in = 8'h00;
        bus.ui_in  = 8'h00;

        // Reset values while held
        repeat (2) @(negedge clk);
        check("reset_uo_out", bus.uo_out, 8'h77);
        check("reset_uio_out", bus.uio_out, 8'h00);
        check("reset_uio_oe", bus.uio_oe, 8'h07);

        // Forward sequence, first step on edge 256
        @(negedge clk);
        rst_n = 1'b1;
        at_edge(255);
        check("pre_first_step", bus.uo_out, 8'h77);
        for (int i = 0; i < 6; i++) begin
            at_edge(i == 0 ? 1 : 256);
            check("fwd_uo_out", bus.uo_out, fwd_uo[i]);
            check("fwd_index", bus.uio_out, 8'((i + 1) % 6));
        end

        // Reverse from reset
        do_reset(8'h04);
        at_edge(256);
        check("rev_first_uo", bus.uo_out, 8'h80);
        check("rev_first_index", bus.uio_out, 8'h05);
        at_edge(256);
        check("rev_second_uo", bus.uo_out, 8'h79);

        // s = 1 steps every 512; dropping to s = 0 at count 400 steps next edge
        do_reset(8'h10);
        at_edge(511);
        check("s1_before_step", bus.uo_out, 8'h77);
        at_edge(1);
        check("s1_first_step", bus.uo_out, 8'hB8);
        at_edge(512);
        at_edge(400);
        check("s1_count400", bus.uo_out, 8'h06);
        @(negedge clk);
        bus.ui_in = 8'h00;
        at_edge(1);
        check("speed_drop_step", bus.uo_out, 8'hBE);

        // Pause at count 100 for 1000 cycles; 156 unpaused edges remain to the step
        do_reset(8'h00);
        at_edge(100);
        @(negedge clk);
        bus.ui_in = 8'h01;
        at_edge(1000);
        check("paused_hold", bus.uo_out, 8'h77);
        @(negedge clk);
        bus.ui_in = 8'h00;
        at_edge(155);
        check("resume_pre_step", bus.uo_out, 8'h77);
        at_edge(1);
        check("resume_step", bus.uo_out, 8'hB8);

        // Blank: segments dark, index and heartbeat still move
        do_reset(8'h02);
        at_edge(100);
        check("blank_reset_uo", bus.uo_out, 8'h00);
        at_edge(156);
        check("blank_step1_uo", bus.uo_out, 8'h80);
        check("blank_step1_index", bus.uio_out, 8'h01);
        at_edge(256);
        check("blank_step2_uo", bus.uo_out, 8'h00);
        check("blank_step2_index", bus.uio_out, 8'h02);

        // Random mix of pause/blank/reverse/speed with occasional mid-count reset
        do_reset(8'h00);
        for (int seg_i = 0; seg_i < 40; seg_i++) begin
            logic [7:0] ui;
            ui[0]   = ($urandom_range(0, 3) == 0);
            ui[1]   = $urandom_range(0, 1) != 0;
            ui[2]   = $urandom_range(0, 1) != 0;
            ui[3]   = $urandom_range(0, 1) != 0;
            ui[7:4] = 4'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                do_reset(ui);
            end else begin
                @(negedge clk);
                bus.ui_in = ui;
            end
            repeat ($urandom_range(50, 700)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
